// File: rtl/multisim_server_pull.sv
// Server-side receiving end of a multisim push channel: polls the multisim server
// for packets pushed by remote clients and presents them through a small FWFT FIFO.

package multisim_server_pkg;

`ifdef MULTISIM_SIMULATION_4_STATE
  typedef logic multisim_data_t;
`else
  typedef bit multisim_data_t;
`endif

  // Widest packet the server interface can carry; DATA_WIDTH must not exceed it.
  localparam int MAX_WIDTH = 256;
  typedef multisim_data_t [MAX_WIDTH-1:0] multisim_word_t;

  // In-process server backend.
  string          srv_dir = "";
  string          srv_name = "";
  int unsigned    srv_start_calls = 32'd0;
  int unsigned    srv_pull_calls = 32'd0;
  multisim_word_t srv_q[$];

  function automatic void multisim_server_start(input string dir, input string name);
    srv_dir = dir;
    srv_name = name;
    srv_start_calls++;
  endfunction

  function automatic void multisim_client_push_packed(input string name, input multisim_word_t data);
    if (name.len() > 0) begin
      srv_q.push_back(data);
    end
  endfunction

  function automatic int multisim_server_pull_packed(input string name,
                                                     output multisim_word_t data,
                                                     input int width);
    multisim_word_t mask_v;
    mask_v = '1;
    if (width < MAX_WIDTH) begin
      mask_v = mask_v >> (MAX_WIDTH - width);
    end
    data = '0;
    srv_pull_calls++;
    if (srv_q.size() == 0 || name != srv_name) begin
      return 32'sd0;
    end
    data = srv_q.pop_front() & mask_v;
    return 32'sd1;
  endfunction

endpackage

module multisim_server_pull #(
  parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
  parameter int    DATA_WIDTH               = 64,
  parameter int    FIFO_DEPTH               = 4,
  parameter type   multisim_data_t          = multisim_server_pkg::multisim_data_t
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  string                                 server_name,
  output logic                                  data_vld,
  input  logic                                  data_rdy,
  output multisim_data_t [DATA_WIDTH-1:0]       data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    WAIT_START = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t                          state_r;
  state_t                          state_nxt_s;
  bit                              started;
  multisim_data_t [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  multisim_data_t [DATA_WIDTH-1:0] pull_word_s;
  logic [PW-1:0]                   wr_ptr_r;
  logic [PW-1:0]                   rd_ptr_r;
  logic [LW-1:0]                   level_r;
  logic                            pop_s;
  logic                            pull_en_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end
    return ptr + PW'(1);
  endfunction

  // Exactly one server call per invocation; returns whether a packet was delivered.
  function automatic logic try_pull(input string name, output multisim_data_t [DATA_WIDTH-1:0] word);
    multisim_server_pkg::multisim_word_t pulled_v;
    int                                  ret_v;
    ret_v = multisim_server_pkg::multisim_server_pull_packed(name, pulled_v, DATA_WIDTH);
    word = pulled_v[DATA_WIDTH-1:0];
    return (ret_v & 32'sd1) != 32'sd0;
  endfunction

  // Connect to the server once the channel is named; survives later resets.
  initial begin
`ifndef MULTISIM_EMULATION
    wait (server_name != "");
`endif
    multisim_server_pkg::multisim_server_start(SERVER_RUNTIME_DIRECTORY, server_name);
    started = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_START;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: RUN is entered once the server connection exists and is left only by reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_START: begin
        if (started) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = WAIT_START;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = WAIT_START;
    endcase
  end

  // Handshake decode; a pop frees a slot, so a full FIFO may still pull.
  always_comb begin
    pop_s     = (level_r != '0) && data_rdy;
    pull_en_s = 1'b0;
    if (state_r == RUN) begin
      pull_en_s = (level_r < DEPTH_L) || pop_s;
    end else begin
      pull_en_s = 1'b0;
    end
  end

  // FIFO storage, pointers and occupancy; storage is cleared so data reads 0 until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (pull_en_s) begin
        if (try_pull(server_name, pull_word_s)) begin
          mem_r[wr_ptr_r] <= pull_word_s;
          wr_ptr_r        <= ptr_inc(wr_ptr_r);
          if (!pop_s) begin
            level_r <= level_r + LW'(1);
          end
        end else if (pop_s) begin
          level_r <= level_r - LW'(1);
        end
      end else if (pop_s) begin
        level_r <= level_r - LW'(1);
      end
    end
  end

  assign data_vld   = (level_r != '0);
  assign data       = mem_r[rd_ptr_r];
  assign fifo_level = level_r;

endmodule

// File: tb/tb_multisim_server_pull.sv
// Randomized bench for multisim_server_pull against a queue-based model of the
// server backlog and of the FIFO contents.

module tb_multisim_server_pull;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef multisim_server_pkg::multisim_word_t word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  string         server_name;
  logic          data_rdy;
  logic          data_vld;
  logic [DW-1:0] data;
  logic [LW-1:0] fifo_level;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_srv[$];
  bit            m_run = 1'b0;
  bit            m_started = 1'b0;
  int unsigned   m_calls = 0;
  int unsigned   calls_snap;

  always #5 clk = ~clk;

  multisim_server_pull #(
    .SERVER_RUNTIME_DIRECTORY("../output_top"),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .server_name(server_name),
    .data_vld(data_vld),
    .data_rdy(data_rdy),
    .data(data),
    .fifo_level(fifo_level)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_vld"}, DW'(data_vld), DW'(m_fifo.size() != 0));
    check_eq({tag, "_level"}, DW'(fifo_level), DW'(m_fifo.size()));
    if (m_fifo.size() != 0) begin
      check_eq({tag, "_data"}, data, m_fifo[0]);
    end
    check_eq({tag, "_calls"}, DW'(multisim_server_pkg::srv_pull_calls), DW'(m_calls));
  endtask

  task automatic push_pkt(input logic [DW-1:0] v);
    m_srv.push_back(v);
    multisim_server_pkg::multisim_client_push_packed("ch0", word_t'(v));
  endtask

  // One clock edge of the reference model, then compare a little after the edge.
  task automatic step(input string tag);
    bit pop;
    bit pull;
    @(posedge clk);
    if (rst_n) begin
      pop  = (m_fifo.size() != 0) && data_rdy;
      pull = m_run && ((m_fifo.size() < DEPTH) || pop);
      if (pull) m_calls++;
      if (pop) void'(m_fifo.pop_front());
      if (pull && m_srv.size() != 0) m_fifo.push_back(m_srv.pop_front());
      if (m_started) m_run = 1'b1;
    end
    #1;
    check_state(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    data_rdy    = 1'b0;
    server_name = "";
    #1;
    check_eq("reset_vld", DW'(data_vld), 64'd0);
    check_eq("reset_level", DW'(fifo_level), 64'd0);
    check_eq("reset_data", data, 64'd0);
    for (int i = 0; i < 3; i++) step("in_reset");
    rst_n = 1'b1;

    // Unconfigured channel: no server traffic at all.
    for (int i = 0; i < 10; i++) step("unnamed");
    server_name = "ch0";
    m_started   = 1'b1;
    push_pkt(64'hA5);
    step("start_edge");
    check_eq("start_no_pull_yet", DW'(multisim_server_pkg::srv_pull_calls), 64'd0);
    step("first_pull");
    check_eq("start_head", data, 64'hA5);
    check_eq("start_calls", DW'(multisim_server_pkg::srv_start_calls), 64'd1);

    // Streaming with the sink always ready.
    data_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) push_pkt(DW'(i));
    for (int i = 0; i < 20; i++) begin
      step("stream");
      check_eq("stream_level_le1", DW'(fifo_level <= LW'(1)), 64'd1);
    end

    // Backpressure: FIFO saturates and pulling stops.
    data_rdy = 1'b0;
    for (int i = 0; i < 10; i++) push_pkt({$urandom, $urandom});
    for (int i = 0; i < 6; i++) step("bp_fill");
    check_eq("bp_level_full", DW'(fifo_level), 64'd4);
    check_eq("bp_stub_left", DW'(multisim_server_pkg::srv_q.size()), 64'd6);
    calls_snap = multisim_server_pkg::srv_pull_calls;
    for (int i = 0; i < 3; i++) step("bp_hold");
    check_eq("bp_no_calls", DW'(multisim_server_pkg::srv_pull_calls), DW'(calls_snap));
    data_rdy = 1'b1;
    step("full_push_pop");
    check_eq("full_push_pop_level", DW'(fifo_level), 64'd4);
    check_eq("full_push_pop_stub", DW'(multisim_server_pkg::srv_q.size()), 64'd5);
    for (int i = 0; i < 12; i++) step("bp_drain");

    // Empty server: a call every cycle, nothing buffered.
    calls_snap = multisim_server_pkg::srv_pull_calls;
    for (int i = 0; i < 20; i++) step("empty_srv");
    check_eq("empty_calls", DW'(multisim_server_pkg::srv_pull_calls - calls_snap), 64'd20);
    check_eq("empty_vld", DW'(data_vld), 64'd0);

    // Reset with three packets buffered and two still waiting at the server.
    data_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push_pkt(64'hC0 + DW'(i));
    for (int i = 0; i < 4; i++) step("rst_fill");
    check_eq("rst_pre_level", DW'(fifo_level), 64'd3);
    push_pkt(64'hB1);
    push_pkt(64'hB2);
    rst_n = 1'b0;
    m_fifo.delete();
    m_run = 1'b0;
    #1;
    check_eq("rst_async_vld", DW'(data_vld), 64'd0);
    check_eq("rst_async_level", DW'(fifo_level), 64'd0);
    check_eq("rst_async_data", data, 64'd0);
    for (int i = 0; i < 2; i++) step("rst_hold");
    rst_n = 1'b1;
    calls_snap = multisim_server_pkg::srv_pull_calls;
    step("rst_release");
    check_eq("rst_release_no_call", DW'(multisim_server_pkg::srv_pull_calls), DW'(calls_snap));
    step("rst_resume");
    check_eq("rst_resume_head", data, 64'hB1);
    check_eq("rst_no_restart", DW'(multisim_server_pkg::srv_start_calls), 64'd1);

    // Random traffic and random sink readiness.
    for (int i = 0; i < 400; i++) begin
      data_rdy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) push_pkt({$urandom, $urandom});
      step("random");
    end
    data_rdy = 1'b1;
    for (int i = 0; i < 200; i++) step("final_drain");
    check_eq("final_empty", DW'(fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
